// File: rtl/ir_key_decode_pkg.sv
// Shared definitions for the NEC key decoder: FSM encoding, frame field layout,
// default timing constants and the complement check.
`timescale 1ns/1ps
package ir_key_decode_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    PRESS   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int FRAME_W   = 32;
  localparam int FIELD_W   = 8;
  localparam int ADDR_LSB  = 24;
  localparam int ADDRN_LSB = 16;
  localparam int CMD_LSB   = 8;
  localparam int CMDN_LSB  = 0;

  localparam int TMO_MS_DEF  = 120;
  localparam int RPT_DIV_DEF = 4;

  // Extended NEC reuses the ~addr byte as the address high byte, so it is
  // only checked when chk_addr is set.
  function automatic logic nec_valid(input logic [FRAME_W-1:0] f,
                                     input logic               chk_addr);
    logic cmd_ok;
    logic addr_ok;
    cmd_ok  = (f[CMD_LSB +: FIELD_W] == ~f[CMDN_LSB +: FIELD_W]);
    addr_ok = (f[ADDR_LSB +: FIELD_W] == ~f[ADDRN_LSB +: FIELD_W]);
    return cmd_ok && (addr_ok || !chk_addr);
  endfunction

endpackage

// File: rtl/ir_key_decode_ms_tick.sv
// Free-running prescaler: one-cycle clock enable every TICK_DIV clocks.
`timescale 1ns/1ps
module ms_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/ir_key_decode.sv
// NEC frame validator and key hold/release tracker with typematic repeat and
// millisecond release timeout.
`timescale 1ns/1ps
module ir_key_decode
  import ir_key_decode_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_DIV = CLK_HZ / 1000,
  parameter int TMO_MS   = TMO_MS_DEF,
  parameter int RPT_DIV  = RPT_DIV_DEF,
  parameter int CHK_ADDR = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FRAME_W-1:0]   i_frame,
  input  logic                 i_frame_vld,
  input  logic                 i_rpt_vld,
  output logic [FIELD_W-1:0]   o_key,
  output logic [2*FIELD_W-1:0] o_addr,
  output logic                 o_key_vld,
  output logic                 o_rel,
  output logic                 o_err,
  output logic                 o_held,
  output logic [7:0]           o_rpt_cnt
);

  localparam logic [7:0] TMO_B = 8'(TMO_MS);
  localparam logic [7:0] RPT_B = 8'(RPT_DIV);

  state_t             state;
  state_t             next_state;
  logic [FRAME_W-1:0] frame_q;
  logic               from_press;
  logic [7:0]         ms_cnt;
  logic               tick;
  logic               frame_ok;
  logic               timeout;
  logic [7:0]         rpt_next;
  logic               typematic;

  ms_tick #(.TICK_DIV(TICK_DIV)) u_ms_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign frame_ok  = nec_valid(frame_q, CHK_ADDR != 0);
  assign timeout   = (ms_cnt >= TMO_B);
  assign rpt_next  = (o_rpt_cnt == 8'hFF) ? 8'hFF : o_rpt_cnt + 8'd1;
  assign typematic = ((rpt_next % RPT_B) == 8'd0);
  assign o_rel     = (state == RELEASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Priority in PRESS: new frame, then repeat, then timeout.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (i_frame_vld) next_state = CHECK;
      CHECK:   next_state = (frame_ok || from_press) ? PRESS : IDLE;
      PRESS: begin
        if (i_frame_vld)    next_state = CHECK;
        else if (i_rpt_vld) next_state = PRESS;
        else if (timeout)   next_state = RELEASE;
      end
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q    <= '0;
      from_press <= 1'b0;
      ms_cnt     <= '0;
      o_key      <= '0;
      o_addr     <= '0;
      o_key_vld  <= 1'b0;
      o_err      <= 1'b0;
      o_held     <= 1'b0;
      o_rpt_cnt  <= '0;
    end else begin
      o_key_vld <= 1'b0;
      o_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_frame_vld) begin
            frame_q    <= i_frame;
            from_press <= 1'b0;
          end
        end
        CHECK: begin
          if (frame_ok) begin
            o_key     <= frame_q[CMD_LSB +: FIELD_W];
            o_addr    <= (CHK_ADDR != 0) ? {8'h00, frame_q[ADDR_LSB +: FIELD_W]}
                                         : frame_q[ADDRN_LSB +: 2*FIELD_W];
            o_key_vld <= 1'b1;
            o_rpt_cnt <= '0;
            ms_cnt    <= '0;
            o_held    <= 1'b1;
          end else begin
            o_err <= 1'b1;
          end
        end
        PRESS: begin
          if (tick && ms_cnt != 8'hFF) ms_cnt <= ms_cnt + 8'd1;
          if (i_frame_vld) begin
            frame_q    <= i_frame;
            from_press <= 1'b1;
          end else if (i_rpt_vld) begin
            ms_cnt    <= '0;
            o_rpt_cnt <= rpt_next;
            o_key_vld <= typematic;
          end else if (timeout) begin
            o_held <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
